// File: rtl/fp_pkg.sv
// Shared floating-point constants and state encodings for the FP datapath
// (fp_divider, fp_multiplier).
package fp_pkg;

  localparam int EXP_W     = 8;
  localparam int MANT_W    = 23;
  localparam int BIAS      = 2 ** (EXP_W - 1) - 1;
  localparam int DIV_ITERS = MANT_W + 3;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] INF  = 32'h7F80_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_NORM = 2'd2,
    ST_RND  = 2'd3
  } state_t;

  // Result class decided at operand capture; SP_NONE means a normal quotient.
  typedef enum logic [1:0] {
    SP_NONE = 2'd0,
    SP_NAN  = 2'd1,
    SP_INF  = 2'd2,
    SP_ZERO = 2'd3
  } special_t;

  // Special-case classification of num1 / num2 (denormals count as zero).
  function automatic special_t classify_div(input logic [31:0] a, input logic [31:0] b);
    logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    a_zero = (a[30:23] == '0);
    b_zero = (b[30:23] == '0);
    a_inf  = (a[30:23] == '1) && (a[22:0] == '0);
    b_inf  = (b[30:23] == '1) && (b[22:0] == '0);
    a_nan  = (a[30:23] == '1) && (a[22:0] != '0);
    b_nan  = (b[30:23] == '1) && (b[22:0] != '0);
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return SP_NAN;
    if (b_zero || a_inf) return SP_INF;
    if (a_zero || b_inf) return SP_ZERO;
    return SP_NONE;
  endfunction

endpackage

// File: rtl/fp_divider_if.sv
// Operand/result handshake bundle for the FP divider.
interface fp_divider_if;
  logic        en;
  logic [31:0] num1;
  logic [31:0] num2;
  logic [31:0] res;
  logic        val;
  logic        busy;

  modport master (output en, num1, num2, input res, val, busy);
  modport slave  (input en, num1, num2, output res, val, busy);
endinterface

// File: rtl/mant_divider.sv
// Unsigned restoring divider: one quotient bit per clock, MSB (integer bit) first.
// Produces floor(dividend/divisor * 2^(DIV_ITERS-1)) plus a sticky bit for the remainder.
module mant_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] dividend,
  input  logic [23:0] divisor,
  output logic [25:0] quot,
  output logic        sticky,
  output logic        done
);

  logic [4:0]  cnt_q;
  logic [24:0] rem_q;
  logic [23:0] div_q;
  logic [25:0] quot_q;
  logic        fits;
  logic [24:0] rem_d;

  // Trial subtraction; the partial remainder stays below twice the divisor so 25 bits suffice.
  always_comb begin
    fits  = (rem_q >= {1'b0, div_q});
    rem_d = fits ? (rem_q - {1'b0, div_q}) : rem_q;
  end

  // Iteration down-counter, remainder and quotient shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      div_q  <= '0;
      quot_q <= '0;
    end else if (start) begin
      cnt_q  <= 5'(DIV_ITERS);
      rem_q  <= {1'b0, dividend};
      div_q  <= divisor;
      quot_q <= '0;
    end else if (cnt_q != '0) begin
      cnt_q  <= cnt_q - 5'd1;
      rem_q  <= rem_d << 1;
      quot_q <= {quot_q[24:0], fits};
    end
  end

  assign quot   = quot_q;
  assign sticky = |rem_q;
  // High during the final iteration so the caller can leave its divide state on that edge.
  assign done   = (cnt_q == 5'd1);

endmodule

// File: rtl/fp_divider.sv
// Sequential IEEE-754 single-precision divider, res = num1 / num2, fixed 28-cycle latency.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for en; operands captured on the accepting edge
//   ST_DIV  | mantissa divider producing 26 quotient bits
//   ST_NORM | align quotient so the hidden bit is set, extract guard/sticky
//   ST_RND  | round-to-nearest-even, range check, write res and strobe val
module fp_divider
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  fp_divider_if.slave bus
);

  state_t          state_q, state_d;
  logic            capture;
  logic            sign_q;
  special_t        spec_q;
  logic signed [9:0] exp_q;
  logic signed [9:0] exp_cap;
  logic [22:0]     frac_q;
  logic            guard_q;
  logic            rs_q;
  logic [31:0]     res_q, res_d;
  logic            val_q;

  logic [25:0]     quot;
  logic            sticky;
  logic            div_done;

  logic            inc;
  logic [23:0]     frac_sum;
  logic signed [9:0] exp_r;

  assign capture = (state_q == ST_IDLE) && bus.en;
  assign exp_cap = {2'b00, bus.num1[30:23]} - {2'b00, bus.num2[30:23]} + 10'(BIAS);

  mant_divider u_mant_div (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (capture),
    .dividend ({1'b1, bus.num1[22:0]}),
    .divisor  ({1'b1, bus.num2[22:0]}),
    .quot     (quot),
    .sticky   (sticky),
    .done     (div_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (bus.en)   state_d = ST_DIV;
      ST_DIV:  if (div_done) state_d = ST_NORM;
      ST_NORM:               state_d = ST_RND;
      ST_RND:                state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  // Capture sign/exponent/special class, then normalise the quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_q  <= 1'b0;
      spec_q  <= SP_NONE;
      exp_q   <= '0;
      frac_q  <= '0;
      guard_q <= 1'b0;
      rs_q    <= 1'b0;
    end else if (capture) begin
      sign_q <= bus.num1[31] ^ bus.num2[31];
      spec_q <= classify_div(bus.num1, bus.num2);
      exp_q  <= exp_cap;
    end else if (state_q == ST_NORM) begin
      if (quot[25]) begin
        frac_q  <= quot[24:2];
        guard_q <= quot[1];
        rs_q    <= quot[0] | sticky;
      end else begin
        // Quotient below 1: the bit after guard is not computed, but only its OR with sticky matters.
        frac_q  <= quot[23:1];
        guard_q <= quot[0];
        rs_q    <= sticky;
        exp_q   <= exp_q - 10'sd1;
      end
    end
  end

  // Round-to-nearest-even, carry renormalisation, range limits and special overrides.
  always_comb begin
    inc      = guard_q & (rs_q | frac_q[0]);
    frac_sum = {1'b0, frac_q} + {23'd0, inc};
    exp_r    = exp_q + 10'(frac_sum[23]);
    res_d    = {sign_q, exp_r[7:0], frac_sum[22:0]};
    unique case (spec_q)
      SP_NAN:  res_d = QNAN;
      SP_INF:  res_d = {sign_q, INF[30:0]};
      SP_ZERO: res_d = {sign_q, 31'd0};
      default: begin
        if (exp_r >= 10'sd255)    res_d = {sign_q, INF[30:0]};
        else if (exp_r <= 10'sd0) res_d = {sign_q, 31'd0};
      end
    endcase
  end

  // Result register and one-cycle strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q <= '0;
      val_q <= 1'b0;
    end else begin
      val_q <= (state_q == ST_RND);
      if (state_q == ST_RND) res_q <= res_d;
    end
  end

  assign bus.res  = res_q;
  assign bus.val  = val_q;
  assign bus.busy = (state_q != ST_IDLE);

endmodule
